sap1_controller_sequencer: RTL and testbench

//   Control/sequencer for the SAP-1 datapath. Directly upstream of the ALU: it drives alu_su/alu_en and the

---
 rtl/sap1_ctrl_pkg.sv | 67 ++++++
 rtl/sap1_ring_counter.sv | 25 ++
 rtl/sap1_controller_sequencer.sv | 173 +++++++++++++++++
 tb/tb_sap1_controller_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sap1_ctrl_pkg.sv
// Shared SAP-1 control definitions: opcodes, ALU select codes, sequencer phase
// encoding and control-word bit positions (used by the controller and the ALU).
package sap1_ctrl_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [2:0] SU_ADD = 3'b000;
    localparam logic [2:0] SU_SUB = 3'b001;
    localparam logic [2:0] SU_AND = 3'b010;
    localparam logic [2:0] SU_OR  = 3'b011;
    localparam logic [2:0] SU_XOR = 3'b100;
    localparam logic [2:0] SU_NOT = 3'b101;

    // INIT and HALT live outside the ring counter; RUN means T1..T6 are live.
    typedef enum logic [1:0] {
        PH_INIT = 2'd0,
        PH_RUN  = 2'd1,
        PH_HALT = 2'd2
    } phase_t;

    localparam int TSTATES = 6;
    localparam int T1_BIT  = 0;
    localparam int T2_BIT  = 1;
    localparam int T3_BIT  = 2;
    localparam int T4_BIT  = 3;
    localparam int T5_BIT  = 4;
    localparam int T6_BIT  = 5;

    localparam int CW_PC_EN    = 0;
    localparam int CW_PC_INC   = 1;
    localparam int CW_MAR_LOAD = 2;
    localparam int CW_MEM_EN   = 3;
    localparam int CW_IR_LOAD  = 4;
    localparam int CW_IR_EN    = 5;
    localparam int CW_A_LOAD   = 6;
    localparam int CW_A_EN     = 7;
    localparam int CW_B_LOAD   = 8;
    localparam int CW_OUT_LOAD = 9;
    localparam int CW_ALU_EN   = 10;
    localparam int CW_BITS     = 11;

    // Two-operand ALU instructions share the same memory-fetch micro-sequence.
    function automatic logic is_binary_alu(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    function automatic logic [2:0] alu_select(input logic [3:0] op);
        case (op)
            OP_ADD:  return SU_ADD;
            OP_SUB:  return SU_SUB;
            OP_AND:  return SU_AND;
            OP_OR:   return SU_OR;
            OP_XOR:  return SU_XOR;
            OP_NOT:  return SU_NOT;
            default: return SU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T1..T6 ring counter for the SAP-1 sequencer; clear forces T1 and
// takes priority over advance.
module sap1_ring_counter
    import sap1_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               advance,
    output logic [TSTATES-1:0] t
);

    localparam logic [TSTATES-1:0] T_FIRST = TSTATES'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t <= T_FIRST;
        end else if (clear) begin
            t <= T_FIRST;
        end else if (advance) begin
            t <= {t[TSTATES-2:0], t[TSTATES-1]};
        end
    end

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller/sequencer: INIT/RUN/HALT wrapper around the T-state ring plus
// combinational control-word decode. Optional single-step mode: SAP1_STEP_MODE_EN.
module sap1_controller_sequencer
    import sap1_ctrl_pkg::*;
#(
    parameter int OPW = 4,
    parameter int SUW = 3
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] ir_opcode,
`ifdef SAP1_STEP_MODE_EN
    input  logic           step,
`endif
    output logic           pc_en,
    output logic           pc_inc,
    output logic           mar_load,
    output logic           mem_en,
    output logic           ir_load,
    output logic           ir_en,
    output logic           a_load,
    output logic           a_en,
    output logic           b_load,
    output logic           out_load,
    output logic           alu_en,
    output logic [SUW-1:0] alu_su,
    output logic [5:0]     tstate,
    output logic           halted
);

    logic adv;

`ifdef SAP1_STEP_MODE_EN
    logic step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    // One advance per rising edge of step, however long it is held.
    assign adv = step & ~step_q;
`else
    assign adv = 1'b1;
`endif

    phase_t             phase;
    phase_t             phase_next;
    logic               ring_clear;
    logic               ring_adv;
    logic [TSTATES-1:0] t;

    sap1_ring_counter u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (ring_clear),
        .advance (ring_adv),
        .t       (t)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_INIT;
        end else begin
            phase <= phase_next;
        end
    end

    always_comb begin
        phase_next = phase;
        ring_clear = 1'b0;
        ring_adv   = 1'b0;
        case (phase)
            PH_INIT: begin
                if (adv) begin
                    phase_next = PH_RUN;
                    ring_clear = 1'b1;
                end
            end
            PH_RUN: begin
                if (adv) begin
                    if (t[T4_BIT] && (ir_opcode == OP_HLT)) begin
                        phase_next = PH_HALT;
                    end else begin
                        ring_adv = 1'b1;
                    end
                end
            end
            PH_HALT: begin
                phase_next = PH_HALT;
            end
            default: begin
                phase_next = PH_INIT;
            end
        endcase
    end

    logic [CW_BITS-1:0] cw;
    logic [SUW-1:0]     su;

    // Raw control word for the current T-state; gated by phase and adv below.
    always_comb begin
        cw = '0;
        su = '0;
        if (phase == PH_RUN) begin
            case (1'b1)
                t[T1_BIT]: begin
                    cw[CW_PC_EN]    = 1'b1;
                    cw[CW_MAR_LOAD] = 1'b1;
                end
                t[T2_BIT]: begin
                    cw[CW_PC_INC] = 1'b1;
                end
                t[T3_BIT]: begin
                    cw[CW_MEM_EN]  = 1'b1;
                    cw[CW_IR_LOAD] = 1'b1;
                end
                t[T4_BIT]: begin
                    if ((ir_opcode == OP_LDA) || is_binary_alu(ir_opcode)) begin
                        cw[CW_IR_EN]    = 1'b1;
                        cw[CW_MAR_LOAD] = 1'b1;
                    end else if (ir_opcode == OP_OUT) begin
                        cw[CW_A_EN]     = 1'b1;
                        cw[CW_OUT_LOAD] = 1'b1;
                    end
                end
                t[T5_BIT]: begin
                    if (ir_opcode == OP_LDA) begin
                        cw[CW_MEM_EN] = 1'b1;
                        cw[CW_A_LOAD] = 1'b1;
                    end else if (is_binary_alu(ir_opcode)) begin
                        cw[CW_MEM_EN] = 1'b1;
                        cw[CW_B_LOAD] = 1'b1;
                    end
                end
                t[T6_BIT]: begin
                    if (is_binary_alu(ir_opcode) || (ir_opcode == OP_NOT)) begin
                        cw[CW_ALU_EN] = 1'b1;
                        cw[CW_A_LOAD] = 1'b1;
                        su            = alu_select(ir_opcode);
                    end
                end
                default: begin
                    cw = '0;
                end
            endcase
        end
    end

    logic [CW_BITS-1:0] cw_out;

    assign cw_out   = adv ? cw : '0;

    assign pc_en    = cw_out[CW_PC_EN];
    assign pc_inc   = cw_out[CW_PC_INC];
    assign mar_load = cw_out[CW_MAR_LOAD];
    assign mem_en   = cw_out[CW_MEM_EN];
    assign ir_load  = cw_out[CW_IR_LOAD];
    assign ir_en    = cw_out[CW_IR_EN];
    assign a_load   = cw_out[CW_A_LOAD];
    assign a_en     = cw_out[CW_A_EN];
    assign b_load   = cw_out[CW_B_LOAD];
    assign out_load = cw_out[CW_OUT_LOAD];
    assign alu_en   = cw_out[CW_ALU_EN];
    assign alu_su   = cw_out[CW_ALU_EN] ? su : '0;

    assign tstate   = (phase == PH_RUN) ? t : '0;
    assign halted   = (phase == PH_HALT);

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Randomised self-checking bench for sap1_controller_sequencer against an
// instruction-level model; define SAP1_STEP_MODE_EN to exercise single-step mode.
module tb_sap1_controller_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ir_opcode;
`ifdef SAP1_STEP_MODE_EN
    logic       step;
`endif
    logic       pc_en, pc_inc, mar_load, mem_en, ir_load, ir_en;
    logic       a_load, a_en, b_load, out_load, alu_en;
    logic [2:0] alu_su;
    logic [5:0] tstate;
    logic       halted;

    always #5 clk = ~clk;

    sap1_controller_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir_opcode (ir_opcode),
`ifdef SAP1_STEP_MODE_EN
        .step      (step),
`endif
        .pc_en     (pc_en),
        .pc_inc    (pc_inc),
        .mar_load  (mar_load),
        .mem_en    (mem_en),
        .ir_load   (ir_load),
        .ir_en     (ir_en),
        .a_load    (a_load),
        .a_en      (a_en),
        .b_load    (b_load),
        .out_load  (out_load),
        .alu_en    (alu_en),
        .alu_su    (alu_su),
        .tstate    (tstate),
        .halted    (halted)
    );

    // Model state: 0 = INIT, 1..6 = T1..T6, 7 = HALT.
    int   mst = 0;
    logic step_prev = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   pc_inc_seen = 0;

    // Expected strobes {pc_en,pc_inc,mar_load,mem_en,ir_load,ir_en,a_load,a_en,b_load,out_load,alu_en,alu_su}.
    function automatic logic [13:0] expCtrl(input int st, input logic [3:0] op);
        logic p_en = 0, p_inc = 0, mar = 0, mem = 0, irl = 0, ire = 0;
        logic al = 0, ae = 0, bl = 0, ol = 0, ue = 0;
        logic [2:0] s = 3'b000;
        bit alu2 = (op >= 4'd1) && (op <= 4'd5);
        case (st)
            1: begin p_en = 1; mar = 1; end
            2: p_inc = 1;
            3: begin mem = 1; irl = 1; end
            4: if (op == 4'd0 || alu2) begin ire = 1; mar = 1; end
               else if (op == 4'd14) begin ae = 1; ol = 1; end
            5: if (op == 4'd0) begin mem = 1; al = 1; end
               else if (alu2) begin mem = 1; bl = 1; end
            6: if (alu2 || op == 4'd6) begin ue = 1; al = 1; s = 3'(op - 4'd1); end
            default: ;
        endcase
        return {p_en, p_inc, mar, mem, irl, ire, al, ae, bl, ol, ue, s};
    endfunction

    function automatic int nextState(input int st, input logic [3:0] op);
        if (st == 7) return 7;
        if (st == 4 && op == 4'd15) return 7;
        if (st == 6) return 1;
        return st + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic adv, input logic [3:0] op);
        logic [13:0] obs, exp;
        logic [5:0]  exp_t;
        int          drivers;
        obs   = {pc_en, pc_inc, mar_load, mem_en, ir_load, ir_en,
                 a_load, a_en, b_load, out_load, alu_en, alu_su};
        exp   = adv ? expCtrl(mst, op) : 14'd0;
        exp_t = (mst >= 1 && mst <= 6) ? 6'(1 << (mst - 1)) : 6'd0;
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s ctrl st=%0d op=%b: observed %b expected %b", tag, mst, op, obs, exp);
        end
        vectors++;
        assert (tstate === exp_t) else begin
            miscompares++;
            $error("[TB] FAIL %s tstate st=%0d: observed %b expected %b", tag, mst, tstate, exp_t);
        end
        vectors++;
        assert (halted === (mst == 7)) else begin
            miscompares++;
            $error("[TB] FAIL %s halted st=%0d: observed %b expected %b", tag, mst, halted, (mst == 7));
        end
        drivers = $countones({pc_en, mem_en, ir_en, a_en, alu_en});
        vectors++;
        assert (drivers <= 1) else begin
            miscompares++;
            $error("[TB] FAIL %s bus_drivers st=%0d: observed %0d expected <=1", tag, mst, drivers);
        end
    endtask

    task automatic driveCycle(input logic [3:0] op, input logic s);
        logic adv;
        @(negedge clk);
        rst_n     = 1'b1;
        ir_opcode = op;
`ifdef SAP1_STEP_MODE_EN
        step = s;
        adv  = s & ~step_prev;
`else
        adv  = 1'b1;
`endif
        #1;
        checkOutput("cycle", adv, op);
        if (pc_inc === 1'b1) pc_inc_seen++;
        if (adv) mst = nextState(mst, op);
        step_prev = s;
    endtask

    task automatic applyStimulus(input logic [3:0] op);
`ifdef SAP1_STEP_MODE_EN
        driveCycle(op, ~step_prev);
`else
        driveCycle(op, 1'b1);
`endif
    endtask

    task automatic pulseReset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
`ifdef SAP1_STEP_MODE_EN
        step = 1'b0;
`endif
        mst       = 0;
        step_prev = 1'b0;
        #1;
        checkOutput("reset", 1'b0, ir_opcode);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            #1;
            checkOutput("reset", 1'b0, ir_opcode);
        end
    endtask

    // Opcode is random during fetch and held at op from T4 through T6.
    task automatic runInstr(input logic [3:0] op);
        logic [3:0] cur;
        int         n = 0;
        bit         started = 0;
        do begin
            cur = (mst >= 4 && mst <= 6) ? op : 4'($urandom_range(0, 15));
            applyStimulus(cur);
            n++;
            if (mst >= 4) started = 1;
        end while (!(started && (mst == 1 || mst == 7)) && n < 60);
        vectors++;
        assert (n < 60) else begin
            miscompares++;
            $error("[TB] FAIL instr_timeout op=%b: observed %0d cycles expected <60", op, n);
        end
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        ir_opcode = 4'd0;
`ifdef SAP1_STEP_MODE_EN
        step = 1'b0;
`endif
        $display("[TB] start");

        pulseReset(3);
        runInstr(4'b0001);
        for (int op = 2; op <= 6; op++) runInstr(4'(op));
        runInstr(4'b0000);
        runInstr(4'b1110);
        runInstr(4'b0111);
        repeat (30) runInstr(4'($urandom_range(0, 14)));

        runInstr(4'b1111);
        repeat (20) applyStimulus(4'($urandom_range(0, 15)));
        pulseReset(1);
        runInstr(4'b0001);

        n = 0;
        while (mst != 5 && n < 40) begin
            applyStimulus((mst >= 4) ? 4'b0001 : 4'($urandom_range(0, 15)));
            n++;
        end
        pulseReset(2);
        runInstr(4'b0010);

`ifdef SAP1_STEP_MODE_EN
        driveCycle(4'($urandom_range(0, 15)), 1'b0);
        pc_inc_seen = 0;
        repeat (5) driveCycle(4'($urandom_range(0, 15)), 1'b1);
        repeat (3) driveCycle(4'($urandom_range(0, 15)), 1'b0);
        driveCycle(4'($urandom_range(0, 15)), 1'b1);
        repeat (3) driveCycle(4'($urandom_range(0, 15)), 1'b1);
        vectors++;
        assert (pc_inc_seen === 1) else begin
            miscompares++;
            $error("[TB] FAIL step_pc_inc: observed %0d cycles expected 1", pc_inc_seen);
        end
        runInstr(4'b0011);
`endif

        repeat (10) runInstr(4'($urandom_range(0, 14)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
